// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC sequencer states, next-PC source codes and default vectors.
package pipe_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_t;

    localparam logic [2:0] PC_SRC_SEQ  = 3'd0;
    localparam logic [2:0] PC_SRC_EXC  = 3'd1;
    localparam logic [2:0] PC_SRC_ERET = 3'd2;
    localparam logic [2:0] PC_SRC_BR   = 3'd3;
    localparam logic [2:0] PC_SRC_JMP  = 3'd4;
    localparam logic [2:0] PC_SRC_PEND = 3'd5;
    localparam logic [2:0] PC_SRC_KEEP = 3'd6;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_next_mux.sv
// Fixed-priority next-PC select with redirect-target alignment trap.
module pc_next_mux #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(pipe_pkg::EXC_VECTOR),
    parameter int               INC        = 4
) (
    input  logic             active,
    input  logic             in_hold,
    input  logic             stall,
    input  logic             exc_valid,
    input  logic             eret,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp_valid,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] epc,
    input  logic [WIDTH-1:0] pend_pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] next_pc,
    output logic [WIDTH-1:0] fault_pc,
    output logic [2:0]       src,
    output logic             misaligned
);
    import pipe_pkg::*;

    logic [WIDTH-1:0] target_s;

    assign pc_plus = pc + WIDTH'(INC);

    // Priority select; nothing is loaded while booting.
    always_comb begin
        src = PC_SRC_KEEP;
        if (!active) begin
            src = PC_SRC_KEEP;
        end else if (exc_valid) begin
            src = PC_SRC_EXC;
        end else if (eret) begin
            src = PC_SRC_ERET;
        end else if (br_taken && !stall) begin
            src = PC_SRC_BR;
        end else if (jmp_valid && !stall) begin
            src = PC_SRC_JMP;
        end else if (in_hold && !stall) begin
            src = PC_SRC_PEND;
        end else if (!stall) begin
            src = PC_SRC_SEQ;
        end else begin
            src = PC_SRC_KEEP;
        end
    end

    // Candidate target for the chosen source, then misaligned-redirect trap.
    always_comb begin
        target_s   = pc;
        misaligned = 1'b0;
        case (src)
            PC_SRC_EXC:  target_s = EXC_VECTOR;
            PC_SRC_ERET: target_s = epc;
            PC_SRC_BR:   target_s = br_target;
            PC_SRC_JMP:  target_s = jmp_target;
            PC_SRC_PEND: target_s = pend_pc;
            PC_SRC_SEQ:  target_s = pc_plus;
            default:     target_s = pc;
        endcase
        if ((src == PC_SRC_BR || src == PC_SRC_JMP || src == PC_SRC_PEND) &&
            (target_s[1:0] != 2'b00)) begin
            misaligned = 1'b1;
        end else begin
            misaligned = 1'b0;
        end
    end

    assign fault_pc = target_s;
    assign next_pc  = misaligned ? EXC_VECTOR : target_s;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register, stall/redirect buffering FSM, EPC capture and fetch counter.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(pipe_pkg::RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(pipe_pkg::EXC_VECTOR),
    parameter int               INC          = 4,
    parameter int               COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [WIDTH-1:0]   br_target,
    input  logic               jmp_valid,
    input  logic [WIDTH-1:0]   jmp_target,
    input  logic               exc_valid,
    input  logic [WIDTH-1:0]   exc_pc,
    input  logic               eret,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   pc_plus,
    output logic               fetch_valid,
    output logic               redirect,
    output logic               align_fault,
    output logic [WIDTH-1:0]   epc,
    output logic [COUNT_W-1:0] fetch_count
);
    import pipe_pkg::*;

    localparam logic [1:0] ST_BOOT = BOOT;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HOLD = HOLD;

    logic [1:0]       state_r, state_next_s;
    logic [WIDTH-1:0] pc_r, epc_r, pend_pc_r;
    logic [COUNT_W-1:0] count_r;
    logic [WIDTH-1:0] next_pc_s, fault_pc_s;
    logic [2:0]       src_s;
    logic             misaligned_s, active_s, trap_s;
    logic             capture_br_s, capture_jmp_s;

    assign active_s = (state_r != ST_BOOT);
    assign trap_s   = active_s && (exc_valid || eret);

    pc_next_mux #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR),
        .INC        (INC)
    ) u_next_mux (
        .active     (active_s),
        .in_hold    (state_r == ST_HOLD),
        .stall      (stall),
        .exc_valid  (exc_valid),
        .eret       (eret),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .pc         (pc_r),
        .epc        (epc_r),
        .pend_pc    (pend_pc_r),
        .pc_plus    (pc_plus),
        .next_pc    (next_pc_s),
        .fault_pc   (fault_pc_s),
        .src        (src_s),
        .misaligned (misaligned_s)
    );

    // A jump never displaces an already-buffered target: the older instruction wins.
    assign capture_br_s  = active_s && !trap_s && stall && br_taken;
    assign capture_jmp_s = (state_r == ST_RUN) && !trap_s && stall && !br_taken && jmp_valid;

    // Next FSM state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: state_next_s = ST_RUN;
            ST_RUN:  state_next_s = (capture_br_s || capture_jmp_s) ? ST_HOLD : ST_RUN;
            ST_HOLD: state_next_s = (!trap_s && stall) ? ST_HOLD : ST_RUN;
            default: state_next_s = ST_BOOT;
        endcase
    end

    assign redirect    = (src_s != PC_SRC_SEQ) && (src_s != PC_SRC_KEEP);
    assign align_fault = misaligned_s;
    assign fetch_valid = active_s && !stall;

    // PC, EPC, pending target, FSM state and fetch counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_BOOT;
            pc_r      <= RESET_VECTOR;
            epc_r     <= {WIDTH{1'b0}};
            pend_pc_r <= {WIDTH{1'b0}};
            count_r   <= {COUNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            pc_r    <= next_pc_s;
            if (active_s && exc_valid) begin
                epc_r <= exc_pc;
            end else if (misaligned_s) begin
                epc_r <= fault_pc_s;
            end else begin
                epc_r <= epc_r;
            end
            if (trap_s) begin
                pend_pc_r <= {WIDTH{1'b0}};
            end else if (capture_br_s) begin
                pend_pc_r <= br_target;
            end else if (capture_jmp_s) begin
                pend_pc_r <= jmp_target;
            end else begin
                pend_pc_r <= pend_pc_r;
            end
            if (fetch_valid) begin
                count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign pc          = pc_r;
    assign epc         = epc_r;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br_taken, jmp_valid, exc_valid, eret;
    logic [31:0] br_target, jmp_target, exc_pc;
    logic [31:0] pc, pc_plus, epc;
    logic        fetch_valid, redirect, align_fault;
    logic [15:0] fetch_count;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] exp_cnt = 16'd0;
    bit          booting = 1'b0;
    logic [15:0] cnt_snap;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .exc_valid   (exc_valid),
        .exc_pc      (exc_pc),
        .eret        (eret),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .fetch_valid (fetch_valid),
        .redirect    (redirect),
        .align_fault (align_fault),
        .epc         (epc),
        .fetch_count (fetch_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic st, input logic br, input logic [31:0] bt,
                          input logic jv, input logic [31:0] jt,
                          input logic ex, input logic [31:0] ep, input logic er);
        stall = st; br_taken = br; br_target = bt; jmp_valid = jv; jmp_target = jt;
        exc_valid = ex; exc_pc = ep; eret = er;
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Advance one clock; the bench counts the fetches it expects.
    task automatic tick();
        if (!booting && !stall) exp_cnt = exp_cnt + 16'd1;
        booting = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_epc", epc, 32'h0);
        check_val("rst_cnt", {16'h0, fetch_count}, 32'h0);
        check_val("rst_fv", {31'h0, fetch_valid}, 32'h0);
        check_val("rst_redir", {31'h0, redirect}, 32'h0);
        check_val("rst_align", {31'h0, align_fault}, 32'h0);

        // Boot cycle then sequential fetch
        reset = 1'b0; booting = 1'b1; exp_cnt = 16'd0;
        #1;
        check_val("boot_fv", {31'h0, fetch_valid}, 32'h0);
        tick();
        check_val("seq_pc0", pc, 32'h0);
        check_val("seq_fv", {31'h0, fetch_valid}, 32'h1);
        check_val("seq_plus", pc_plus, 32'h4);
        tick();
        check_val("seq_pc4", pc, 32'h4);
        tick();
        check_val("seq_pc8", pc, 32'h8);
        check_val("seq_cnt2", {16'h0, fetch_count}, 32'h2);

        // Branch beats jump
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        tick();
        check_val("jmp_pc20", pc, 32'h20);
        set_in(1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        check_val("brjmp_redir", {31'h0, redirect}, 32'h1);
        tick();
        check_val("brjmp_pc", pc, 32'h100);
        idle();
        check_val("brjmp_redir_off", {31'h0, redirect}, 32'h0);

        // Stall buffering: jmp captured, later br overwrites
        cnt_snap = exp_cnt;
        set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        check_val("stall_fv", {31'h0, fetch_valid}, 32'h0);
        check_val("stall_redir", {31'h0, redirect}, 32'h0);
        tick();
        check_val("stall_pc1", pc, 32'h100);
        set_in(1'b1, 1'b1, 32'h60, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check_val("stall_pc2", pc, 32'h100);
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        check_val("stall_pc3", pc, 32'h100);
        check_val("stall_cnt", {16'h0, fetch_count}, {16'h0, cnt_snap});
        idle();
        check_val("release_redir", {31'h0, redirect}, 32'h1);
        check_val("release_fv", {31'h0, fetch_valid}, 32'h1);
        tick();
        check_val("release_pc", pc, 32'h60);

        // Exception during stall clears the pending target
        set_in(1'b1, 1'b1, 32'h70, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h34, 1'b0);
        check_val("exc_redir", {31'h0, redirect}, 32'h1);
        tick();
        check_val("exc_pc", pc, 32'h80);
        check_val("exc_epc", epc, 32'h34);
        idle();
        check_val("exc_nopend", {31'h0, redirect}, 32'h0);
        tick();
        check_val("exc_seq", pc, 32'h84);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        check_val("eret_pc", pc, 32'h34);

        // exc_valid beats eret and updates epc
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h50, 1'b1);
        tick();
        check_val("exceret_pc", pc, 32'h80);
        check_val("exceret_epc", epc, 32'h50);

        // Misaligned branch traps
        set_in(1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_val("mis_align", {31'h0, align_fault}, 32'h1);
        check_val("mis_redir", {31'h0, redirect}, 32'h1);
        tick();
        check_val("mis_pc", pc, 32'h80);
        check_val("mis_epc", epc, 32'h102);
        idle();
        check_val("mis_align_off", {31'h0, align_fault}, 32'h0);

        // PC wrap
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        tick();
        check_val("wrap_top", pc, 32'hFFFF_FFFC);
        idle();
        tick();
        check_val("wrap_zero", pc, 32'h0);

        // Reset mid-HOLD discards the pending target at once
        set_in(1'b1, 1'b1, 32'h90, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        check_val("midrst_pc", pc, 32'h0);
        check_val("midrst_cnt", {16'h0, fetch_count}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0; booting = 1'b1; exp_cnt = 16'd0;
        idle();
        check_val("midrst_boot_redir", {31'h0, redirect}, 32'h0);
        tick();
        check_val("midrst_run_redir", {31'h0, redirect}, 32'h0);
        check_val("midrst_pc0", pc, 32'h0);
        tick();
        check_val("midrst_pc4", pc, 32'h4);

        // Fetch counter wrap
        while (exp_cnt != 16'hFFFF) tick();
        check_val("cnt_max", {16'h0, fetch_count}, 32'h0000_FFFF);
        tick();
        check_val("cnt_wrap", {16'h0, fetch_count}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the pipelined MIPS core. It holds the fetch PC and selects the next PC from five sources in fixed priority: exception, exception return, EX-stage branch, ID-stage jump, sequential increment. It also supports stalls, buffers redirects that arrive while stalled, captures the EPC and counts fetches. It sits at the head of the IF stage and feeds the instruction memory address and the IF/ID register.

## Interface
Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VECTOR, 0, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception or misaligned redirect.
- INC, 4, sequential increment.
- COUNT_W, 16, width of fetch counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hazard unit hold request; PC frozen while high.
- br_taken  in  1  EX-stage branch resolved taken.
- br_target  in  WIDTH  branch target.
- jmp_valid  in  1  ID-stage jump decoded.
- jmp_target  in  WIDTH  jump target.
- exc_valid  in  1  exception raised by a later stage.
- exc_pc  in  WIDTH  PC of the faulting instruction.
- eret  in  1  return from exception.
- pc  out  WIDTH  current fetch PC, registered.
- pc_plus  out  WIDTH  pc + INC, combinational.
- fetch_valid  out  1  pc is a real fetch this cycle.
- redirect  out  1  non-sequential PC load this cycle; flushes IF/ID.
- align_fault  out  1  one-cycle pulse: misaligned redirect target trapped.
- epc  out  WIDTH  saved exception PC, registered.
- fetch_count  out  COUNT_W  number of advanced fetches, wraps.

## Operation
- FSM states:
  - BOOT: first cycle after reset; fetch_valid=0; goes to RUN unconditionally. exc_valid and eret are ignored in BOOT.
  - RUN: normal operation.
  - HOLD: stalled with a buffered redirect in pend_pc.
- Next-PC priority, evaluated every cycle:
  1. exc_valid: pc←EXC_VECTOR, epc←exc_pc, pending cleared. Applies even if stall=1.
  2. eret: pc←epc. Applies even if stall=1. Pending cleared.
  3. br_taken.
  4. jmp_valid.
  5. pending redirect (only when stall=0).
  6. pc+INC (only when stall=0).
- Stalls and buffering:
  - stall=1 with br_taken or jmp_valid: target captured in pend_pc, enter HOLD, pc unchanged.
  - In HOLD, a br_taken target overwrites pend_pc; a jmp_valid target does not, because the older instruction wins.
  - HOLD with stall=0: pc←pend_pc, redirect=1, go to RUN. A same-cycle br_taken wins over pend_pc.
- Alignment: any br/jmp/pending target with bits [1:0]≠0 loads EXC_VECTOR instead, sets epc←that target and pulses align_fault. eret target alignment is not checked.
- Output conditions:
  - redirect=1 whenever the PC loaded this cycle came from sources 1–5.
  - fetch_valid=1 in RUN or HOLD when stall=0; 0 in BOOT or when stall=1.
  - fetch_count increments on every posedge where fetch_valid=1. Wraps from 2^COUNT_W−1 to 0.
- Arithmetic: modulo 2^WIDTH. pc=2^WIDTH−INC advancing yields 0, with no flag.

## Timing
- Reset values: pc=RESET_VECTOR, epc=0, fetch_count=0, pend_pc=0, state=BOOT, fetch_valid=0, redirect=0, align_fault=0.
- Latency: a redirect input at posedge N is visible on pc after posedge N. Sequential advance is also one cycle.
- redirect, align_fault and fetch_valid are combinational from the current state and inputs, valid before the posedge that loads pc.
- Reset asserted mid-HOLD discards the pending redirect immediately (asynchronous).
- exc_valid and eret in the same cycle: exc_valid wins, and epc is updated.

## Structure
- Shared package pipe_pkg:
  - pc_state_t enum (BOOT, RUN, HOLD).
  - PC_SRC_* select constants.
  - Default vectors RESET_VECTOR and EXC_VECTOR.
- One sub-module, pc_next_mux: combinational priority select producing the next PC, the src code and the misaligned flag. Registers and FSM live in pc_sequencer.

## Test plan
- Reset: release reset → BOOT cycle with fetch_valid=0, then pc=0,4,8 on successive cycles; fetch_count=2 after two advances.
- Branch/jump conflict: at pc=0x20 assert br_taken target 0x100 and jmp_valid target 0x200 together → pc=0x100, redirect=1 for one cycle.
- Stall buffering: stall=1 for 3 cycles; jmp 0x40 in cycle 1, br 0x60 in cycle 2 → pc held. After release pc=0x60, redirect=1, fetch_count unchanged during the stall.
- Exception during stall: stall=1 with exc_valid and exc_pc=0x34 → pc=0x80, epc=0x34, pending cleared. Then eret → pc=0x34.
- Misaligned redirect: br_taken target 0x102 → pc=0x80, epc=0x102, align_fault pulses once.
- Wrap: set pc to 0xFFFF_FFFC via a jump → next pc=0. Preload fetch_count to 0xFFFF with COUNT_W=16 → next advance gives 0.
